// File: rtl/leitor_mem_pkg.sv
// Shared types and default sizing for the leitor_mem burst reader.
package leitor_mem_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // Reader FSM: issue address, wait for registered read data, present word.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/leitor_mem_ptr.sv
// Burst address pointer (wraps modulo DEPTH) and remaining-word counter.
module leitor_mem_ptr #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              last_word
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;

    // Next pointer/count: load on accepted start, step once per delivered word.
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        if (load) begin
            ptr_d       = load_base;
            remaining_d = load_count;
        end else if (advance) begin
            // DEPTH is a power of two, so natural overflow gives the wrap to 0.
            ptr_d = ptr_q + ADDR_W'(1);
            if (remaining_q != '0) begin
                remaining_d = remaining_q - (ADDR_W+1)'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    assign ptr       = ptr_q;
    assign last_word = (remaining_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/leitor_mem.sv
// Burst memory reader: reads rd_count words starting at rd_base from a bank
// with one-cycle registered read latency and streams them downstream with a
// valid/ready handshake. Optional running checksum of delivered words is
// enabled by defining LEITOR_MEM_CHECKSUM_EN.
module leitor_mem
    import leitor_mem_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    input  logic [$clog2(DEPTH):0]     rd_count,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic                       mem_rd_en,
    input  logic [WIDTH-1:0]           mem_q,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
`ifdef LEITOR_MEM_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]           checksum
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              done_q, done_d;

    logic [ADDR_W:0]   count_clamped;
    logic              start_accept;
    logic              xfer;
    logic [ADDR_W-1:0] ptr;
    logic              last_word;

    // Requests longer than the bank are read as one full pass.
    assign count_clamped = (rd_count > DEPTH_CNT) ? DEPTH_CNT : rd_count;
    assign start_accept  = (state_q == IDLE) && start;
    assign xfer          = (state_q == OUT) && out_ready;

    leitor_mem_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (start_accept),
        .load_base  (rd_base),
        .load_count (count_clamped),
        .advance    (xfer),
        .ptr        (ptr),
        .last_word  (last_word)
    );

    // FSM next state, read-data capture and completion pulse.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_clamped == '0) begin
                        // Empty burst completes immediately.
                        done_d = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Bank output is valid one cycle after the strobe.
                out_data_d = mem_q;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, output word and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    // Outputs decoded from the registered state, so reset forces them low.
    assign mem_rd_en = (state_q == ADDR);
    assign mem_addr  = mem_rd_en ? ptr : '0;
    assign out_valid = (state_q == OUT);
    assign out_last  = out_valid && last_word;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

`ifdef LEITOR_MEM_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    // Running sum of delivered words, restarted by each accepted start.
    always_comb begin
        checksum_d = checksum_q;
        if (start_accept) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_leitor_mem.sv
// Self-checking bench for leitor_mem with a scoreboard of expected words.
module tb_leitor_mem;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [WIDTH-1:0]  mem_q;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef LEITOR_MEM_CHECKSUM_EN
    logic [WIDTH-1:0]  checksum;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int rd_en_cnt = 0;
    int done_cnt  = 0;
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always #5 clk = ~clk;

    leitor_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_base   (rd_base),
        .rd_count  (rd_count),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef LEITOR_MEM_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // Memory bank model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_q <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: score every transfer, count strobes and done pulses.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_rd_en) rd_en_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                $display("xfer data=%02h last=%0d", out_data, out_last);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("xfer_data", 32'(out_data), 32'(e.data));
                    check_eq("xfer_last", 32'(out_last), 32'(e.last));
                end
            end else if (out_last && !out_valid) begin
                check_eq("last_without_valid", 32'(out_last), 32'd0);
            end
        end
    end

    task automatic push_burst(input int base, input int count);
        int n;
        n = (count > DEPTH) ? DEPTH : count;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = mem[(base + i) % DEPTH];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Start is sampled on the first rising edge after this task raises it.
    task automatic issue_start(input int base, input int count);
        @(posedge clk); #1;
        rd_base  = ADDR_W'(base);
        rd_count = (ADDR_W+1)'(count);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // n = index of the falling edge (counted from the accepting edge) where done is seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rd_addr(input int addr);
        int k;
        k = 0;
        while (!(mem_rd_en && mem_addr == ADDR_W'(addr)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check_eq("rd_addr_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_burst(input string tag, input int base, input int count, input int exp_n);
        int n;
        int words;
        words = (count > DEPTH) ? DEPTH : count;
        push_burst(base, count);
        rd_en_cnt = 0;
        issue_start(base, count);
        wait_done(n);
        if (exp_n >= 0) check_eq({tag, "_done_cycle"}, 32'(n), 32'(exp_n));
        check_eq({tag, "_rd_en_count"}, 32'(rd_en_cnt), 32'(words));
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
        reset = 1'b0; start = 1'b0; rd_base = '0; rd_count = '0; out_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Full burst: 8 words x 3 cycles, done seen in the cycle after the last transfer.
        run_burst("full", 0, 8, 25);

        // Wrap-around burst.
        run_burst("wrap", 6, 4, 13);

        // Over-long request clamps to DEPTH words.
        run_burst("clamp", 2, 12, 25);

        // Empty burst: only a done pulse, one cycle after start.
        rd_en_cnt = 0;
        issue_start(3, 0);
        @(negedge clk);
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("zero_idle_busy", 32'(busy), 32'd0);
            check_eq("zero_idle_valid", 32'(out_valid), 32'd0);
            check_eq("zero_idle_done", 32'(done), 32'd0);
        end
        check_eq("zero_rd_en_count", 32'(rd_en_cnt), 32'd0);

        // Back-pressure on word 2: output must hold, no extra reads.
        push_burst(0, 8);
        rd_en_cnt = 0;
        issue_start(0, 8);
        wait_rd_addr(2);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), 32'h12);
            check_eq("stall_rd_en", 32'(mem_rd_en), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_done(n);
        check_eq("stall_rd_en_count", 32'(rd_en_cnt), 32'd8);
        check_eq("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Start while busy is ignored; burst and checksum keep original request.
        push_burst(0, 8);
        rd_en_cnt = 0;
        issue_start(0, 8);
        repeat (4) @(negedge clk);
        rd_base = 3'd5; rd_count = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_eq("busy_start_rd_en_count", 32'(rd_en_cnt), 32'd8);
        check_eq("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef LEITOR_MEM_CHECKSUM_EN
        check_eq("checksum_at_done", 32'(checksum), 32'h9C);
        repeat (3) @(negedge clk);
        check_eq("checksum_hold", 32'(checksum), 32'h9C);
`endif

        // Reset during WAIT of word 3 aborts the burst without done.
        push_burst(0, 3);
        exp_q[2].last = 1'b0;
        issue_start(0, 8);
        wait_rd_addr(3);
        @(posedge clk); #1;
        k = done_cnt;
        reset = 1'b1;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_out_data", 32'(out_data), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
`ifdef LEITOR_MEM_CHECKSUM_EN
        check_eq("abort_checksum", 32'(checksum), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt), 32'(k));
        check_eq("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        run_burst("post_abort", 0, 2, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
